// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receiver.
package uart_pkg;

  localparam int unsigned OVS       = 16;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Oversample divisor, truncated; never below 1 so the tick generator stays legal.
  function automatic int unsigned ovs_div(input int unsigned clk_freq, input int unsigned baud);
    int unsigned div;
    div = clk_freq / (baud * OVS);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running 16x-baud oversample tick; clr re-phases the counter to zero.
module uart_rx_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, one-byte holding register,
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun
);

  localparam int unsigned OvsDiv = ovs_div(CLK_FREQ, BAUD);
  localparam int unsigned BitW   = $clog2(DATA_BITS);
  localparam logic [3:0] SMid    = 4'(OVS / 2 - 1);
  localparam logic [3:0] SLast   = 4'(OVS - 1);

  logic rx_meta_q, rx_s;
  logic tick, tick_clr;

  rx_state_e            state_q, state_d;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, overrun_q, overrun_d;
  logic                 frame_good, frame_bad;

  uart_rx_tick_gen #(
    .DIV (OvsDiv)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tick_clr   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d  = StStart;
          s_cnt_d  = '0;
          tick_clr = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_cnt_q == SMid) begin
            s_cnt_d   = '0;
            bit_idx_d = '0;
            // A line that is high again at mid-bit was only a glitch.
            state_d   = rx_s ? StIdle : StData;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_cnt_q == SLast) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d   = '0;
            bit_idx_d = bit_idx_q + BitW'(1);
            if (bit_idx_q == BitW'(DATA_BITS - 1)) begin
              state_d = StStop;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (s_cnt_q == SLast) begin
            s_cnt_d = '0;
            if (rx_s) begin
              frame_good = 1'b1;
              state_d    = StIdle;
            end else begin
              frame_bad = 1'b1;
              state_d   = StBreak;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      StBreak: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A consume in the completion cycle frees the slot for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (frame_good) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      s_cnt_q       <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_cnt_q       <= s_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= frame_bad;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: bytes, error pulses and latency checked against a frame-level model.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned BIT_CLKS = CLK_FREQ / BAUD;
  // Stop-bit sample edge: 2 sync cycles plus 9.5 bit times after the line falls.
  localparam int unsigned DONE_EDGE = 2 + (BIT_CLKS * 19) / 2;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun;

  int n_tests;
  int n_fail;
  int fe_cnt;
  int ov_cnt;
  int valid_cycles;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedges; observe just after, values hold through the next posedge.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (framing_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    fe_cnt       = 0;
    ov_cnt       = 0;
    valid_cycles = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    rx = stop_bit;
    idle(BIT_CLKS);
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq({tag, "_byte"}, got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int unsigned lat;
    int          exp_fe;
    int          exp_valid;
    logic [7:0]  b;
    logic        bad;

    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    clear_obs();

    idle(3);
    #1;
    check_eq("rst_data", rx_data, 8'h00);
    check_eq("rst_valid", rx_valid, 1'b0);
    check_eq("rst_ferr", framing_err, 1'b0);
    check_eq("rst_ovr", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(20);

    // Single good frame with latency measurement.
    clear_obs();
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rx_valid && lat < 3000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    idle(20);
    exp_q.push_back(8'hA5);
    check_eq("a5_latency", lat, DONE_EDGE + 1);
    check_rx("a5");
    check_eq("a5_valid_cycles", valid_cycles, 1);
    check_eq("a5_ferr", fe_cnt, 0);
    check_eq("a5_ovr", ov_cnt, 0);

    // Short low glitch is rejected, then a real frame still gets through.
    clear_obs();
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(300);
    check_eq("glitch_valid", valid_cycles, 0);
    check_eq("glitch_ferr", fe_cnt, 0);
    check_eq("glitch_ovr", ov_cnt, 0);
    send_frame(8'hC3, 1'b1);
    idle(20);
    exp_q.push_back(8'hC3);
    check_rx("after_glitch");

    // Bad stop bit, line held low: one framing pulse, no restart until high.
    clear_obs();
    send_frame(8'h3C, 1'b0);
    idle(500);
    check_eq("brk_ferr", fe_cnt, 1);
    check_eq("brk_valid", valid_cycles, 0);
    rx = 1'b1;
    idle(40);
    send_frame(8'h55, 1'b1);
    idle(20);
    exp_q.push_back(8'h55);
    check_rx("after_brk");
    check_eq("brk_ferr_total", fe_cnt, 1);
    check_eq("brk_ovr", ov_cnt, 0);

    // Overrun: second frame dropped while holding register is full.
    clear_obs();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(40);
    send_frame(8'h22, 1'b1);
    idle(40);
    check_eq("ovr_data", rx_data, 8'h11);
    check_eq("ovr_valid", rx_valid, 1'b1);
    check_eq("ovr_pulse", ov_cnt, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check_eq("ovr_drain_valid", rx_valid, 1'b0);
    exp_q.push_back(8'h11);
    check_rx("ovr");

    // Consume in the exact completion cycle: new byte loads without overrun.
    clear_obs();
    send_frame(8'h11, 1'b1);
    idle(40);
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle(DONE_EDGE);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    check_eq("same_data", rx_data, 8'h22);
    check_eq("same_valid", rx_valid, 1'b1);
    check_eq("same_ovr", ov_cnt, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    idle(5);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check_rx("same");

    // Reset during data bit 4 aborts the frame; the next frame is clean.
    clear_obs();
    rx_ready = 1'b0;
    send_frame(8'h99, 1'b1);
    idle(20);
    check_eq("pre_rst_valid", rx_valid, 1'b1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        idle(BIT_CLKS * 5 + 80);
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", rx_valid, 1'b0);
        check_eq("midrst_data", rx_data, 8'h00);
        check_eq("midrst_ferr", framing_err, 1'b0);
        check_eq("midrst_ovr", overrun, 1'b0);
        idle(10);
        rst = 1'b1;
      end
    join
    idle(20);
    check_eq("midrst_quiet_valid", rx_valid, 1'b0);
    check_eq("midrst_quiet_ferr", fe_cnt, 0);
    check_eq("midrst_quiet_ovr", ov_cnt, 0);
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b1);
    idle(20);
    exp_q.push_back(8'h81);
    check_rx("after_rst");

    // Random frames, some with a bad stop bit, consumer always ready.
    clear_obs();
    exp_fe    = 0;
    exp_valid = 0;
    for (int f = 0; f < 12; f++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, !bad);
      if (bad) begin
        idle($urandom_range(20, 300));
        rx = 1'b1;
        exp_fe++;
        idle($urandom_range(20, 60));
      end else begin
        exp_q.push_back(b);
        exp_valid++;
        idle($urandom_range(0, 60));
      end
    end
    idle(20);
    check_rx("rand");
    check_eq("rand_ferr", fe_cnt, exp_fe);
    check_eq("rand_ovr", ov_cnt, 0);
    check_eq("rand_valid_cycles", valid_cycles, exp_valid);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: line bit rate in bits/s.
REQ-003 Port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-low.
REQ-005 Port rx  input  1: serial line, idle high; asynchronous to clk.
REQ-006 Port rx_data  output  8: last accepted byte.
REQ-007 Port rx_valid  output  1: rx_data holds an unconsumed byte.
REQ-008 Port rx_ready  input  1: consumer accepts rx_data when rx_valid and rx_ready are both high on a clock edge.
REQ-009 Port framing_err  output  1: one-cycle pulse, stop bit sampled low.
REQ-010 Port overrun  output  1: one-cycle pulse, frame completed while the holding register was full.

Function
REQ-011 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-013 Oversample tick SHALL be 16x BAUD: divisor OVS_DIV = CLK_FREQ/(BAUD*16), integer-truncated; counter 0..OVS_DIV-1; tick is a one-cycle pulse at OVS_DIV-1.
REQ-014 Tick counter SHALL be cleared on IDLE->START so start-bit sampling is phase-aligned to the detected falling edge.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: rx_s == 0 -> START, sample counter s_cnt = 0.
REQ-017 START: on tick with s_cnt == 7, rx_s == 0 -> DATA (s_cnt = 0, bit index = 0); rx_s == 1 -> IDLE (glitch rejected, no output activity).
REQ-018 DATA: on tick with s_cnt == 15, shift rx_s into the MSB of the shift register (right shift), s_cnt = 0, bit index +1; after bit index 7 -> STOP.
REQ-019 STOP: on tick with s_cnt == 15, rx_s == 1 -> frame good, -> IDLE; rx_s == 0 -> framing_err pulse, byte discarded, -> BREAK.
REQ-020 BREAK: remain until rx_s == 1, then -> IDLE; no start detection while in BREAK.
REQ-021 s_cnt SHALL be 4 bits and increment on every tick not consumed by a transition above.
REQ-022 Good frame with rx_valid == 0: rx_data loaded, rx_valid set on the next clock edge.
REQ-023 Good frame with rx_valid == 1 and rx_ready == 1 in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
REQ-024 Good frame with rx_valid == 1 and rx_ready == 0: new byte dropped, rx_data unchanged, overrun pulse for one cycle.
REQ-025 rx_valid SHALL clear on the edge where rx_valid && rx_ready, unless REQ-023 applies.
REQ-026 rx_data SHALL remain stable while rx_valid is high, except under REQ-023.
REQ-027 Latency: rx_valid rises one clk after the stop-bit sample tick (about 9.5 bit times after the start edge plus 2 sync cycles).

Reset
REQ-028 When rst is low: FSM = IDLE, all counters 0, shift register 0, rx_data = 0, rx_valid = 0, framing_err = 0, overrun = 0, both synchronizer flops = 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no rx_valid, framing_err or overrun; reception resumes with the next falling edge after release.

Structure
REQ-030 Package uart_pkg SHALL hold the rx FSM state enum, the OVS = 16 constant and the DATA_BITS = 8 constant.
REQ-031 Oversample tick generation SHALL be a sub-module uart_rx_tick_gen (clk, rst, clr, tick).

Verification
Simulation parameters: CLK_FREQ = 1_600_000, BAUD = 10_000 -> OVS_DIV = 10, 160 clk per bit.
REQ-032 Drive 0xA5 8N1 with rx_ready = 1 -> one rx_valid cycle, rx_data = 0xA5, no error pulses.
REQ-033 Drive rx low for 40 clk, then high -> FSM returns to IDLE; no rx_valid, framing_err or overrun.
REQ-034 Drive 0x3C with stop bit 0, hold low 500 clk, then high -> one framing_err pulse, no rx_valid, FSM stays in BREAK until rx high; next 0x55 frame received correctly.
REQ-035 rx_ready = 0, frames 0x11 then 0x22 -> rx_data = 0x11 held, one overrun pulse at the end of the 0x22 frame; rx_ready = 1 then clears rx_valid.
REQ-036 rx_valid = 1 (0x11) with rx_ready pulsed in the exact completion cycle of 0x22 -> rx_data = 0x22, rx_valid stays 1, no overrun.
REQ-037 Assert rst during DATA bit 4 of 0xF0 -> all outputs 0 immediately; after release, frame 0x81 -> rx_data = 0x81.
